write_txn_scheduler: RTL and testbench

WRITE_TXN_SCHEDULER -- requirements
Module: write_txn_scheduler

---
 rtl/axi_sched_pkg.sv | 44 ++++
 rtl/write_addr_decode.sv | 22 ++
 rtl/write_txn_scheduler.sv | 165 ++++++++++++++++
 tb/tb_write_txn_scheduler.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/axi_sched_pkg.sv
// Shared types and constants for the AXI write-transaction scheduler:
// FSM encoding, one-hot slave selects, decode regions and the arbitration helper.
package axi_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } sched_state_e;

    localparam logic [2:0] SLV_NONE = 3'b000;
    localparam logic [2:0] SLV_S0   = 3'b001;
    localparam logic [2:0] SLV_S1   = 3'b010;
    localparam logic [2:0] SLV_DEF  = 3'b100;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // Inclusive address windows; anything outside both goes to the default slave.
    localparam logic [31:0] S0_BASE  = 32'h0000_0000;
    localparam logic [31:0] S0_LIMIT = 32'h0000_FFFF;
    localparam logic [31:0] S1_BASE  = 32'h0001_0000;
    localparam logic [31:0] S1_LIMIT = 32'h0001_FFFF;

    // Round-robin pick between two requesters; a tie goes to the one not served last.
    function automatic logic [1:0] rr_pick(input logic vld_m0,
                                           input logic vld_m1,
                                           input logic last_was_m1);
        logic [1:0] pick;
        if (vld_m0 && vld_m1) begin
            pick = last_was_m1 ? GNT_M0 : GNT_M1;
        end else if (vld_m0) begin
            pick = GNT_M0;
        end else if (vld_m1) begin
            pick = GNT_M1;
        end else begin
            pick = GNT_NONE;
        end
        return pick;
    endfunction

endpackage

// File: rtl/write_addr_decode.sv
// Combinational address decoder: maps a 32-bit write address onto a one-hot
// slave select {DEFAULT,S1,S0}.
module write_addr_decode
    import axi_sched_pkg::*;
(
    input  logic [31:0] i_addr,
    output logic [2:0]  o_sel
);

    // Region compare against the package windows.
    always_comb begin
        o_sel = SLV_DEF;
        if ((i_addr >= S0_BASE) && (i_addr <= S0_LIMIT)) begin
            o_sel = SLV_S0;
        end else if ((i_addr >= S1_BASE) && (i_addr <= S1_LIMIT)) begin
            o_sel = SLV_S1;
        end else begin
            o_sel = SLV_DEF;
        end
    end

endmodule

// File: rtl/write_txn_scheduler.sv
// Two-master write-transaction scheduler: arbitrates AW requests round-robin,
// routes to a decoded slave, counts W beats against AWLEN and sequences the B phase.
module write_txn_scheduler
    import axi_sched_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             AWVALID_M0,
    input  logic             AWVALID_M1,
    input  logic [31:0]      AWADDR_M0,
    input  logic [31:0]      AWADDR_M1,
    input  logic [LEN_W-1:0] AWLEN_M0,
    input  logic [LEN_W-1:0] AWLEN_M1,
    input  logic             AWREADY_SEL,
    input  logic             WVALID_SEL,
    input  logic             WLAST_SEL,
    input  logic             WREADY_SEL,
    input  logic             BVALID_SEL,
    input  logic             BREADY_SEL,
    output logic [1:0]       grant,
    output logic [2:0]       slave_sel,
    output logic             aw_phase,
    output logic             w_phase,
    output logic             b_phase,
    output logic             wlast_exp,
    output logic             len_err,
    output logic             busy
);

    sched_state_e      r_state;
    sched_state_e      w_state_nxt;
    logic [1:0]        r_grant;
    logic [2:0]        r_slave_sel;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_beat;
    logic              r_last_m1;
    logic              r_len_err;

    logic [1:0]        w_win;
    logic [31:0]       w_win_addr;
    logic [LEN_W-1:0]  w_win_len;
    logic [2:0]        w_win_sel;
    logic              w_any_req;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_b_hs;
    logic              w_last_beat;

    assign w_any_req   = AWVALID_M0 | AWVALID_M1;
    assign w_win       = rr_pick(AWVALID_M0, AWVALID_M1, r_last_m1);
    assign w_win_addr  = w_win[1] ? AWADDR_M1 : AWADDR_M0;
    assign w_win_len   = w_win[1] ? AWLEN_M1  : AWLEN_M0;
    assign w_aw_hs     = ((r_grant[0] & AWVALID_M0) | (r_grant[1] & AWVALID_M1)) & AWREADY_SEL;
    assign w_w_hs      = WVALID_SEL & WREADY_SEL;
    assign w_b_hs      = BVALID_SEL & BREADY_SEL;
    assign w_last_beat = (r_beat == r_len);

    write_addr_decode u_decode (
        .i_addr (w_win_addr),
        .o_sel  (w_win_sel)
    );

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; W sequencing follows the beat counter, never WLAST_SEL.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) w_state_nxt = ST_ADDR;
                else           w_state_nxt = ST_IDLE;
            end
            ST_ADDR: begin
                if (w_aw_hs) w_state_nxt = ST_DATA;
                else         w_state_nxt = ST_ADDR;
            end
            ST_DATA: begin
                if (w_w_hs && w_last_beat) w_state_nxt = ST_RESP;
                else                       w_state_nxt = ST_DATA;
            end
            ST_RESP: begin
                if (w_b_hs) w_state_nxt = ST_IDLE;
                else        w_state_nxt = ST_RESP;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Transaction context: grant, target, length, beat counter, arbitration history.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_grant     <= GNT_NONE;
            r_slave_sel <= SLV_NONE;
            r_len       <= {LEN_W{1'b0}};
            r_beat      <= {LEN_W{1'b0}};
            r_last_m1   <= 1'b1;
            r_len_err   <= 1'b0;
        end else begin
            r_len_err <= (r_state == ST_DATA) && w_w_hs && (WLAST_SEL != w_last_beat);
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant     <= w_win;
                        r_slave_sel <= w_win_sel;
                        r_len       <= w_win_len;
                    end
                end
                ST_ADDR: begin
                    if (w_aw_hs) begin
                        r_beat <= {LEN_W{1'b0}};
                    end
                end
                ST_DATA: begin
                    // Hold on the final beat so the counter cannot wrap within a burst.
                    if (w_w_hs && !w_last_beat) begin
                        r_beat <= r_beat + {{(LEN_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    if (w_b_hs) begin
                        r_last_m1   <= r_grant[1];
                        r_grant     <= GNT_NONE;
                        r_slave_sel <= SLV_NONE;
                    end
                end
                default: begin
                    r_grant     <= GNT_NONE;
                    r_slave_sel <= SLV_NONE;
                end
            endcase
        end
    end

    // Output decode from registered state only.
    always_comb begin
        grant     = r_grant;
        slave_sel = r_slave_sel;
        len_err   = r_len_err;
        aw_phase  = 1'b0;
        w_phase   = 1'b0;
        b_phase   = 1'b0;
        wlast_exp = 1'b0;
        busy      = 1'b1;
        case (r_state)
            ST_IDLE: busy = 1'b0;
            ST_ADDR: aw_phase = 1'b1;
            ST_DATA: begin
                w_phase   = 1'b1;
                wlast_exp = w_last_beat;
            end
            ST_RESP: b_phase = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_write_txn_scheduler.sv
// Directed bench for write_txn_scheduler: linear stimulus with hand-computed
// expected outputs checked by immediate assertions.
module tb_write_txn_scheduler;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        AWVALID_M0, AWVALID_M1;
    logic [31:0] AWADDR_M0, AWADDR_M1;
    logic [3:0]  AWLEN_M0, AWLEN_M1;
    logic        AWREADY_SEL, WVALID_SEL, WLAST_SEL, WREADY_SEL, BVALID_SEL, BREADY_SEL;
    logic [1:0]  grant;
    logic [2:0]  slave_sel;
    logic        aw_phase, w_phase, b_phase, wlast_exp, len_err, busy;

    int n_vec = 0;
    int n_err = 0;

    write_txn_scheduler #(.LEN_W(4)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .AWVALID_M0  (AWVALID_M0),
        .AWVALID_M1  (AWVALID_M1),
        .AWADDR_M0   (AWADDR_M0),
        .AWADDR_M1   (AWADDR_M1),
        .AWLEN_M0    (AWLEN_M0),
        .AWLEN_M1    (AWLEN_M1),
        .AWREADY_SEL (AWREADY_SEL),
        .WVALID_SEL  (WVALID_SEL),
        .WLAST_SEL   (WLAST_SEL),
        .WREADY_SEL  (WREADY_SEL),
        .BVALID_SEL  (BVALID_SEL),
        .BREADY_SEL  (BREADY_SEL),
        .grant       (grant),
        .slave_sel   (slave_sel),
        .aw_phase    (aw_phase),
        .w_phase     (w_phase),
        .b_phase     (b_phase),
        .wlast_exp   (wlast_exp),
        .len_err     (len_err),
        .busy        (busy)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // flags = {aw_phase, w_phase, b_phase, wlast_exp, len_err, busy}
    task automatic expect_out(input string tag, input logic [1:0] g,
                              input logic [2:0] s, input logic [5:0] flags);
        logic [10:0] obs;
        logic [10:0] exp_v;
        obs   = {grant, slave_sel, aw_phase, w_phase, b_phase, wlast_exp, len_err, busy};
        exp_v = {g, s, flags};
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%b required=%b", tag, obs, exp_v);
        end
    endtask

    initial begin
        ARESET = 1'b1;
        AWVALID_M0 = 1'b0; AWVALID_M1 = 1'b0;
        AWADDR_M0 = 32'h0; AWADDR_M1 = 32'h0;
        AWLEN_M0 = 4'd0; AWLEN_M1 = 4'd0;
        AWREADY_SEL = 1'b1; WVALID_SEL = 1'b0; WLAST_SEL = 1'b0;
        WREADY_SEL = 1'b1; BVALID_SEL = 1'b0; BREADY_SEL = 1'b1;
        tick(); tick();
        ARESET = 1'b0;
        expect_out("reset", 2'b00, 3'b000, 6'b000000);

        // Single master M0, 4-beat burst to S0
        AWVALID_M0 = 1'b1; AWADDR_M0 = 32'h0000_1000; AWLEN_M0 = 4'd3;
        tick(); expect_out("t1_addr", 2'b01, 3'b001, 6'b100001);
        tick(); expect_out("t1_data0", 2'b01, 3'b001, 6'b010001);
        AWVALID_M0 = 1'b0; WVALID_SEL = 1'b1;
        tick(); expect_out("t1_beat1", 2'b01, 3'b001, 6'b010001);
        tick(); expect_out("t1_beat2", 2'b01, 3'b001, 6'b010001);
        tick(); expect_out("t1_beat3_last", 2'b01, 3'b001, 6'b010101);
        WLAST_SEL = 1'b1;
        tick(); expect_out("t1_resp", 2'b01, 3'b001, 6'b001001);
        WVALID_SEL = 1'b0; WLAST_SEL = 1'b0; BVALID_SEL = 1'b1;
        tick(); expect_out("t1_idle", 2'b00, 3'b000, 6'b000000);
        BVALID_SEL = 1'b0;

        // Tie after reset: M0 first, then M1 to S1, back-to-back
        ARESET = 1'b1; tick(); ARESET = 1'b0;
        AWVALID_M0 = 1'b1; AWADDR_M0 = 32'h0000_2000; AWLEN_M0 = 4'd0;
        AWVALID_M1 = 1'b1; AWADDR_M1 = 32'h0001_0000; AWLEN_M1 = 4'd0;
        tick(); expect_out("t2_tie_m0", 2'b01, 3'b001, 6'b100001);
        tick(); expect_out("t2_single_beat", 2'b01, 3'b001, 6'b010101);
        WVALID_SEL = 1'b1; WLAST_SEL = 1'b1;
        tick(); expect_out("t2_resp", 2'b01, 3'b001, 6'b001001);
        WVALID_SEL = 1'b0; WLAST_SEL = 1'b0; BVALID_SEL = 1'b1;
        tick(); expect_out("t2_idle", 2'b00, 3'b000, 6'b000000);
        BVALID_SEL = 1'b0;
        tick(); expect_out("t2_tie_m1", 2'b10, 3'b010, 6'b100001);
        tick(); expect_out("t2_m1_data", 2'b10, 3'b010, 6'b010101);
        AWVALID_M0 = 1'b0; AWVALID_M1 = 1'b0;
        WVALID_SEL = 1'b1; WLAST_SEL = 1'b1;
        tick(); expect_out("t2_m1_resp", 2'b10, 3'b010, 6'b001001);
        WVALID_SEL = 1'b0; WLAST_SEL = 1'b0; BVALID_SEL = 1'b1;
        tick(); expect_out("t2_m1_idle", 2'b00, 3'b000, 6'b000000);
        BVALID_SEL = 1'b0;

        // Default slave, with W and B stalls
        AWVALID_M0 = 1'b1; AWADDR_M0 = 32'h2000_0000; AWLEN_M0 = 4'd1;
        tick(); expect_out("t3_addr_def", 2'b01, 3'b100, 6'b100001);
        tick(); expect_out("t3_data0", 2'b01, 3'b100, 6'b010001);
        AWVALID_M0 = 1'b0; WVALID_SEL = 1'b1; WREADY_SEL = 1'b0;
        tick(); expect_out("t3_wstall", 2'b01, 3'b100, 6'b010001);
        WREADY_SEL = 1'b1;
        tick(); expect_out("t3_beat1_last", 2'b01, 3'b100, 6'b010101);
        WLAST_SEL = 1'b1;
        tick(); expect_out("t3_resp", 2'b01, 3'b100, 6'b001001);
        WVALID_SEL = 1'b0; WLAST_SEL = 1'b0; BVALID_SEL = 1'b1; BREADY_SEL = 1'b0;
        tick(); expect_out("t3_bstall", 2'b01, 3'b100, 6'b001001);
        BREADY_SEL = 1'b1;
        tick(); expect_out("t3_idle", 2'b00, 3'b000, 6'b000000);
        BVALID_SEL = 1'b0;

        // WLAST mismatch: early WLAST on beat 1 of a 2-beat burst
        AWVALID_M0 = 1'b1; AWADDR_M0 = 32'h0001_8000; AWLEN_M0 = 4'd1;
        tick(); expect_out("t4_addr_s1", 2'b01, 3'b010, 6'b100001);
        tick(); expect_out("t4_data0", 2'b01, 3'b010, 6'b010001);
        AWVALID_M0 = 1'b0; WVALID_SEL = 1'b1; WLAST_SEL = 1'b1;
        tick(); expect_out("t4_len_err", 2'b01, 3'b010, 6'b010111);
        tick(); expect_out("t4_resp_no_err", 2'b01, 3'b010, 6'b001001);
        WVALID_SEL = 1'b0; WLAST_SEL = 1'b0; BVALID_SEL = 1'b1;
        tick(); expect_out("t4_idle", 2'b00, 3'b000, 6'b000000);
        BVALID_SEL = 1'b0;

        // AW stalls, then reset in DATA with a W handshake on the same edge
        AWVALID_M0 = 1'b1; AWADDR_M0 = 32'h0000_0000; AWLEN_M0 = 4'd2; AWREADY_SEL = 1'b0;
        tick(); expect_out("t5_addr", 2'b01, 3'b001, 6'b100001);
        AWVALID_M1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            AWVALID_M0  = (i < 3);
            AWREADY_SEL = (i == 4);
            tick(); expect_out($sformatf("t5_stall%0d", i), 2'b01, 3'b001, 6'b100001);
        end
        AWVALID_M0 = 1'b1; AWVALID_M1 = 1'b0; AWREADY_SEL = 1'b1;
        tick(); expect_out("t5_data", 2'b01, 3'b001, 6'b010001);
        AWVALID_M0 = 1'b0; ARESET = 1'b1; WVALID_SEL = 1'b1;
        tick(); expect_out("t5_reset", 2'b00, 3'b000, 6'b000000);
        ARESET = 1'b0; WVALID_SEL = 1'b0;
        AWVALID_M0 = 1'b1; AWADDR_M0 = 32'h0000_0010;
        AWVALID_M1 = 1'b1; AWADDR_M1 = 32'h2000_0000;
        tick(); expect_out("t5_tie_after_reset", 2'b01, 3'b001, 6'b100001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
